// File: rtl/id_ex_latch_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// control bundle layouts, ALU operation encodings and the funct slice width.
package id_ex_latch_pkg;

    // Default datapath and register specifier widths
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    // Control bundle widths
    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

    // WB bundle: {reg_write, mem_to_reg}
    localparam int unsigned WB_REG_WRITE  = 1;
    localparam int unsigned WB_MEM_TO_REG = 0;

    // M bundle: {branch, mem_read, mem_write}
    localparam int unsigned M_BRANCH    = 2;
    localparam int unsigned M_MEM_READ  = 1;
    localparam int unsigned M_MEM_WRITE = 0;

    // EX bundle: {reg_dst, alu_op[1:0], alu_src}
    localparam int unsigned EX_REG_DST   = 3;
    localparam int unsigned EX_ALU_OP_HI = 2;
    localparam int unsigned EX_ALU_OP_LO = 1;
    localparam int unsigned EX_ALU_SRC   = 0;

    // ALU operation class presented to ALU control
    localparam int unsigned ALU_OP_W = 2;
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_MEM   = 2'b00,
        ALU_OP_BEQ   = 2'b01,
        ALU_OP_RTYPE = 2'b10
    } alu_op_e;

    // R-type function field lives in the low bits of the immediate
    localparam int unsigned FUNCT_W = 6;

    // Bubble counter width and saturation value
    localparam int unsigned     BUBBLE_CNT_W   = 16;
    localparam logic [15:0]     BUBBLE_CNT_MAX = 16'hFFFF;

    // Extract the alu_op field from an EX bundle
    function automatic logic [ALU_OP_W-1:0] ex_alu_op(input logic [EX_W-1:0] ex);
        return ex[EX_ALU_OP_HI:EX_ALU_OP_LO];
    endfunction

endpackage

// File: rtl/id_ex_latch_pipe_reg.sv
// Generic pipeline register: synchronous reset, synchronous clear (load zero)
// and load enable. Priority: rst > clr > en.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Next value: clear beats enable, otherwise hold
    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (en) begin
            val_d = d_i;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Captures decode-stage control bundles, operands and register specifiers
// and presents them to execute one cycle later. Supports stall (hold),
// flush (zeroed bubble) and a valid bit.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating 16-bit count of
// flushes taking effect, exposed on bubble_cnt.
import id_ex_latch_pkg::*;

module id_ex_latch #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [WB_W-1:0]     in_wb,
    input  logic [M_W-1:0]      in_m,
    input  logic [EX_W-1:0]     in_ex,
    input  logic [DATA_W-1:0]   in_npc,
    input  logic [DATA_W-1:0]   in_rd1,
    input  logic [DATA_W-1:0]   in_rd2,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic [REG_AW-1:0]   in_rs,
    input  logic [REG_AW-1:0]   in_rt,
    input  logic [REG_AW-1:0]   in_rd,
    output logic                out_valid,
    output logic [WB_W-1:0]     out_wb,
    output logic [M_W-1:0]      out_m,
    output logic [EX_W-1:0]     out_ex,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [FUNCT_W-1:0]  out_funct,
    output logic [DATA_W-1:0]   out_npc,
    output logic [DATA_W-1:0]   out_rd1,
    output logic [DATA_W-1:0]   out_rd2,
    output logic [DATA_W-1:0]   out_imm,
    output logic [REG_AW-1:0]   out_rs,
    output logic [REG_AW-1:0]   out_rt,
    output logic [REG_AW-1:0]   out_rd
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

    localparam int unsigned CTRL_W = 1 + WB_W + M_W + EX_W;
    localparam int unsigned DAT_W  = 4 * DATA_W + 3 * REG_AW;

    logic              load_en;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DAT_W-1:0]  dat_d;
    logic [DAT_W-1:0]  dat_q;

    // Stall only gates the load; flush is applied as a clear, which the
    // register prioritises above the enable, so flush wins over stall.
    assign load_en = ~stall;

    assign ctrl_d = {in_valid, in_wb, in_m, in_ex};
    assign dat_d  = {in_npc, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd};

    pipe_reg #(
        .W (CTRL_W)
    ) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d_i (ctrl_d),
        .q_o (ctrl_q)
    );

    pipe_reg #(
        .W (DAT_W)
    ) u_data_reg (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d_i (dat_d),
        .q_o (dat_q)
    );

    assign {out_valid, out_wb, out_m, out_ex} = ctrl_q;
    assign {out_npc, out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd} = dat_q;

    // Pure wiring slices feeding ALU control
    assign out_alu_op = ex_alu_op(out_ex);
    assign out_funct  = out_imm[FUNCT_W-1:0];

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_d;

    // Count flushes taking effect, saturating at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flush && (bubble_cnt_q != BUBBLE_CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Counter register; reset has priority so flushes under reset are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed-vector bench for id_ex_latch with hand-computed expectations.
// Covers ID_EX_BUBBLE_CNT_EN when the macro is defined.
module tb_id_ex_latch;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [1:0]  in_wb;
    logic [2:0]  in_m;
    logic [3:0]  in_ex;
    logic [31:0] in_npc, in_rd1, in_rd2, in_imm;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        out_valid;
    logic [1:0]  out_wb, out_alu_op;
    logic [2:0]  out_m;
    logic [3:0]  out_ex;
    logic [5:0]  out_funct;
    logic [31:0] out_npc, out_rd1, out_rd2, out_imm;
    logic [4:0]  out_rs, out_rt, out_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    id_ex_latch #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_wb      (in_wb),
        .in_m       (in_m),
        .in_ex      (in_ex),
        .in_npc     (in_npc),
        .in_rd1     (in_rd1),
        .in_rd2     (in_rd2),
        .in_imm     (in_imm),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_wb     (out_wb),
        .out_m      (out_m),
        .out_ex     (out_ex),
        .out_alu_op (out_alu_op),
        .out_funct  (out_funct),
        .out_npc    (out_npc),
        .out_rd1    (out_rd1),
        .out_rd2    (out_rd2),
        .out_imm    (out_imm),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom);
        in_wb    = 2'($urandom);
        in_m     = 3'($urandom);
        in_ex    = 4'($urandom);
        in_npc   = $urandom;
        in_rd1   = $urandom;
        in_rd2   = $urandom;
        in_imm   = $urandom;
        in_rs    = 5'($urandom);
        in_rt    = 5'($urandom);
        in_rd    = 5'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},  64'(out_valid),  64'd0);
        check({tag, ".wb"},     64'(out_wb),     64'd0);
        check({tag, ".m"},      64'(out_m),      64'd0);
        check({tag, ".ex"},     64'(out_ex),     64'd0);
        check({tag, ".alu_op"}, 64'(out_alu_op), 64'd0);
        check({tag, ".funct"},  64'(out_funct),  64'd0);
        check({tag, ".npc"},    64'(out_npc),    64'd0);
        check({tag, ".rd1"},    64'(out_rd1),    64'd0);
        check({tag, ".rd2"},    64'(out_rd2),    64'd0);
        check({tag, ".imm"},    64'(out_imm),    64'd0);
        check({tag, ".rs"},     64'(out_rs),     64'd0);
        check({tag, ".rt"},     64'(out_rt),     64'd0);
        check({tag, ".rd"},     64'(out_rd),     64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_inputs();

        // Reset for two cycles with random inputs
        tick();
        rand_inputs();
        tick();
        check_all_zero("reset");

        // Load an R-type SUB
        rst = 1'b0;
        in_valid = 1'b1; in_wb = 2'b10; in_m = 3'b000; in_ex = 4'b1100;
        in_npc = 32'h0040_0004; in_rd1 = 32'h0000_0011; in_rd2 = 32'h0000_0022;
        in_imm = 32'h0000_0022; in_rs = 5'd8; in_rt = 5'd9; in_rd = 5'd10;
        tick();
        check("load.alu_op", 64'(out_alu_op), 64'h2);
        check("load.funct",  64'(out_funct),  64'h22);
        check("load.valid",  64'(out_valid),  64'h1);
        check("load.wb",     64'(out_wb),     64'h2);
        check("load.ex",     64'(out_ex),     64'hC);
        check("load.npc",    64'(out_npc),    64'h0040_0004);
        check("load.rd2",    64'(out_rd2),    64'h22);
        check("load.rs",     64'(out_rs),     64'd8);
        check("load.rt",     64'(out_rt),     64'd9);
        check("load.rd",     64'(out_rd),     64'd10);

        // Stall holds everything, including valid
        in_rd1 = 32'hDEAD_BEEF; in_m = 3'b010;
        tick();
        check("stall.pre_rd1", 64'(out_rd1), 64'hDEAD_BEEF);
        stall = 1'b1; in_rd1 = 32'h1234_5678; in_valid = 1'b0; in_m = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.rd1",   64'(out_rd1),   64'hDEAD_BEEF);
            check("stall.valid", 64'(out_valid), 64'h1);
            check("stall.m",     64'(out_m),     64'h2);
        end
        stall = 1'b0;
        tick();
        check("release.rd1",   64'(out_rd1),   64'h1234_5678);
        check("release.valid", 64'(out_valid), 64'h0);
        check("release.m",     64'(out_m),     64'h5);

        // Flush with stall: bubble wins
        in_valid = 1'b1; in_wb = 2'b11; in_m = 3'b010; in_ex = 4'b0011;
        stall = 1'b1; flush = 1'b1;
        tick();
        check_all_zero("flush_stall");
        stall = 1'b0; flush = 1'b0;

        // Invalid instruction: fields captured verbatim, not masked
        in_valid = 1'b0; in_wb = 2'b11; in_m = 3'b110; in_ex = 4'b0001;
        in_imm = 32'hFFFF_FFEA; in_rd1 = 32'hA5A5_0000;
        tick();
        check("inv.valid",  64'(out_valid),  64'h0);
        check("inv.wb",     64'(out_wb),     64'h3);
        check("inv.m",      64'(out_m),      64'h6);
        check("inv.ex",     64'(out_ex),     64'h1);
        check("inv.alu_op", 64'(out_alu_op), 64'h0);
        check("inv.funct",  64'(out_funct),  64'h2A);
        check("inv.imm",    64'(out_imm),    64'hFFFF_FFEA);

        // beq: alu_op 01
        in_valid = 1'b1; in_ex = 4'b0010; in_m = 3'b100; in_wb = 2'b00;
        tick();
        check("beq.alu_op", 64'(out_alu_op), 64'h1);
        check("beq.m",      64'(out_m),      64'h4);

        // Reset arriving mid-stall
        in_valid = 1'b1; in_wb = 2'b10; in_rd1 = 32'hCAFE_F00D; in_rs = 5'd31;
        tick();
        check("rstmid.pre_valid", 64'(out_valid), 64'h1);
        stall = 1'b1; rand_inputs();
        tick();
        check("rstmid.hold_rd1", 64'(out_rd1), 64'hCAFE_F00D);
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid_stall");
        rst = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_wb = 2'b01; in_m = 3'b010; in_ex = 4'b0001;
        in_npc = 32'h0000_1008; in_rd1 = 32'h0000_0100; in_rd2 = 32'h0000_0200;
        in_imm = 32'h0000_0004; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
        tick();
        check("after_rst.valid", 64'(out_valid), 64'h1);
        check("after_rst.wb",    64'(out_wb),    64'h1);
        check("after_rst.m",     64'(out_m),     64'h2);
        check("after_rst.rd1",   64'(out_rd1),   64'h100);
        check("after_rst.npc",   64'(out_npc),   64'h1008);

        // Reset arriving mid-flush still yields zeros and a clean first load
        flush = 1'b1; rst = 1'b1;
        tick();
        check_all_zero("rst_mid_flush");
        rst = 1'b0; flush = 1'b0; in_rd2 = 32'h7777_0001;
        tick();
        check("after_rstf.rd2",   64'(out_rd2),   64'h7777_0001);
        check("after_rstf.valid", 64'(out_valid), 64'h1);

`ifdef ID_EX_BUBBLE_CNT_EN
        // Flushes under reset are not counted
        rst = 1'b1; flush = 1'b1;
        tick();
        check("bcnt.reset", 64'(bubble_cnt), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("bcnt.five", 64'(bubble_cnt), 64'd5);
        flush = 1'b0; stall = 1'b1;
        tick();
        check("bcnt.hold", 64'(bubble_cnt), 64'd5);
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 65529; i++) tick();
        check("bcnt.fffe", 64'(bubble_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) tick();
        check("bcnt.sat", 64'(bubble_cnt), 64'hFFFF);
        flush = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the execute-stage ALU control and ALU. Captures decoded control bundles, register-file read data, sign-extended immediate and register specifiers at the end of decode, and presents them to execute one cycle later. Supports stall (hold), flush (bubble insertion) and a valid bit so downstream stages can ignore bubbles.

## Interface
- DATA_W, 32, datapath width (PC, read data, immediate)
- REG_AW, 5, register specifier width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all outputs this cycle
- flush  in  1  load a bubble this cycle
- in_valid  in  1  decode-stage instruction valid
- in_wb  in  2  {reg_write, mem_to_reg}
- in_m  in  3  {branch, mem_read, mem_write}
- in_ex  in  4  {reg_dst, alu_op[1:0], alu_src}
- in_npc  in  DATA_W  PC+4
- in_rd1, in_rd2  in  DATA_W  register-file read data
- in_imm  in  DATA_W  sign-extended immediate
- in_rs, in_rt, in_rd  in  REG_AW  register specifiers
- out_valid  out  1  registered in_valid
- out_wb, out_m, out_ex  out  2/3/4  registered control bundles
- out_alu_op  out  2  out_ex[2:1], feeds ALU control alu_op
- out_funct  out  6  out_imm[5:0], feeds ALU control funct
- out_npc, out_rd1, out_rd2, out_imm  out  DATA_W  registered data
- out_rs, out_rt, out_rd  out  REG_AW  registered specifiers

## Operation
- Per-cycle priority at rising clk: rst > flush > stall > load.
- rst: every registered output = 0 (out_valid 0, all control 0, all data 0); hence out_alu_op = 2'b00, out_funct = 0.
- flush: out_valid, out_wb, out_m, out_ex cleared to 0; data and specifier fields also cleared to 0 (deterministic bubble). Bubble never writes registers or memory.
- stall (flush low): all outputs hold previous value, including out_valid.
- load (neither): all outputs take corresponding inputs; out_valid = in_valid.
- flush and stall together: flush wins; bubble loaded.
- in_valid = 0 during load: fields still captured verbatim; downstream qualifies with out_valid. Control fields are NOT auto-masked on load.
- out_alu_op and out_funct are pure wiring slices, no extra state.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear at outputs after edge N.
- All outputs registered; no combinational input-to-output path.
- stall/flush sampled at the same edge as data; effect visible after that edge.
- rst asserted mid-stall or mid-flush: outputs zero after next edge; first load occurs on the first edge with rst low and stall/flush low.

## Configuration
- ID_EX_BUBBLE_CNT_EN defined: adds output bubble_cnt (16 bits) counting edges on which flush takes effect (rst low); reset to 0; saturates at 16'hFFFF, never wraps.
- Not defined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package: DATA_W/REG_AW defaults, bundle widths (WB_W=2, M_W=3, EX_W=4), bit positions within each bundle, alu_op encodings (00 mem, 01 beq, 10 R-type), funct slice width 6.
- One sub-module: pipe_reg — generic width-parameterised register with synchronous rst, clr (load zero) and en; instantiated per field group (control with clr, data with clr).

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, out_valid=0, out_alu_op=00.
- Load: in_ex=4'b1100, in_imm=32'h0000_0022, in_valid=1 -> next cycle out_alu_op=2'b10, out_funct=6'b100010, out_valid=1.
- Stall: load rd1=32'hDEAD_BEEF, then stall=1 for 3 cycles while in_rd1=32'h1234_5678 -> out_rd1 stays 32'hDEAD_BEEF; releases to 32'h1234_5678 one cycle after stall drops.
- Flush over stall: in_wb=2'b11, in_m=3'b010, flush=1 and stall=1 -> out_wb=0, out_m=0, out_ex=0, out_valid=0, out_rd1=0.
- Reset mid-stall: stall=1 holding valid instruction, rst=1 one cycle -> outputs 0; with rst, stall low, next input loads normally.
- With ID_EX_BUBBLE_CNT_EN: 5 flush cycles -> bubble_cnt=5; preload 16'hFFFE then 3 flushes -> 16'hFFFF.
